// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit seven-segment scan controller with frame-synchronous display update
module seg7_scan_driver #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [1:0]  scan_sel,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [1:0]    r_sel;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_frame;
    logic [15:0]   r_disp;
    logic [15:0]   r_shadow;
    logic          r_pend;

    logic          w_tick;
    logic          w_frame;
    logic [1:0]    w_sel_nx;
    logic [15:0]   w_disp_nx;
    logic [15:0]   w_upper;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [6:0]    w_hex;

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 7'h40;
            4'h1: f_hex = 7'h79;
            4'h2: f_hex = 7'h24;
            4'h3: f_hex = 7'h30;
            4'h4: f_hex = 7'h19;
            4'h5: f_hex = 7'h12;
            4'h6: f_hex = 7'h02;
            4'h7: f_hex = 7'h78;
            4'h8: f_hex = 7'h00;
            4'h9: f_hex = 7'h10;
            4'hA: f_hex = 7'h08;
            4'hB: f_hex = 7'h03;
            4'hC: f_hex = 7'h46;
            4'hD: f_hex = 7'h21;
            4'hE: f_hex = 7'h06;
            default: f_hex = 7'h0E;
        endcase
    endfunction

    // Next-state scan position and display contents; outputs are registered from these so they never lag scan_sel
    always_comb begin
        w_tick    = (r_pre == PW'(CLK_DIV - 1));
        w_frame   = w_tick && (r_sel == 2'd3);
        w_sel_nx  = w_tick ? r_sel + 2'd1 : r_sel;
        w_disp_nx = !w_frame ? r_disp : load ? value : r_pend ? r_shadow : r_disp;
        w_upper   = w_disp_nx >> {w_sel_nx, 2'b00};
        w_nib     = w_upper[3:0];
        w_blank   = blank_lz && (w_sel_nx != 2'd0) && (w_upper == 16'h0);
        w_hex     = w_blank ? 7'h7F : f_hex(w_nib);
    end

    // Prescaler, scan position, shadow buffering and registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_sel    <= 2'd0;
            r_an     <= 4'b1111;
            r_seg    <= 8'hFF;
            r_frame  <= 1'b0;
            r_disp   <= 16'h0;
            r_shadow <= 16'h0;
            r_pend   <= 1'b0;
        end else begin
            r_pre    <= w_tick ? '0 : r_pre + PW'(1);
            r_sel    <= w_sel_nx;
            r_an     <= ~(4'b0001 << w_sel_nx);
            r_seg    <= {~dp_en[w_sel_nx], w_hex};
            r_frame  <= w_frame;
            r_disp   <= w_disp_nx;
            r_shadow <= load ? value : r_shadow;
            r_pend   <= (load && !w_frame) || (r_pend && !w_frame);
        end
    end

    assign scan_sel   = r_sel;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment score display.
- Generates the 2-bit digit select that drives the downstream 4:1 digit-select muxes (S input), the active-low anode enables, and the decoded active-low segment pattern for the selected hex nibble.
- Buffers new display values in a shadow register and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- CLK_DIV, 100000: clock cycles per digit slot (100 MHz gives 1 kHz digit rate, 250 Hz frame rate); legal range ≥ 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- value  in  16  four hex nibbles; nibble i = value[4i+3:4i] shows on digit i; digit 0 is rightmost.
- load  in  1  single-cycle strobe; captures value into the shadow register.
- blank_lz  in  1  1 = suppress leading zeros.
- dp_en  in  4  decimal point enable per digit; sampled live, not buffered.
- scan_sel  out  2  index of the active digit; feeds the mux S input.
- an  out  4  anode enables, active-low, one-hot-low.
- seg  out  8  segments, active-low; seg[0]=a … seg[6]=g, seg[7]=dp.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, any time) sets:
  - prescaler=0, scan_sel=0, an=4'b1111 (all off), seg=8'hFF, frame_done=0.
  - disp_reg=0, shadow=0, pend=0.
  - Reset mid-frame discards any pending load.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle where prescaler==CLK_DIV-1.
- Scan:
  - On a tick edge, scan_sel increments modulo 4 (3 wraps to 0).
  - No change between ticks.
- Frame boundary: the tick edge where scan_sel goes 3→0. On that edge:
  - frame_done=1 for exactly one cycle.
  - If pend=1: disp_reg<=shadow and pend<=0.
- Load:
  - When load=1: shadow<=value, pend<=1.
  - Multiple loads within one frame: last one wins.
  - load in the same cycle as a frame boundary: value goes straight into disp_reg, and pend is left 0.
- an and seg are registered, and each cycle they are computed from the next-state scan_sel and disp_reg. As a result, scan_sel, an and seg are always mutually consistent in every cycle after the first post-reset edge.
- Anode: an = ~(4'b0001 << scan_sel).
- Segment decode, active-low, bits g..a, standard hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Decimal point: seg[7] = ~dp_en[scan_sel].
- Leading-zero blanking:
  - Digit i (i=1..3) is blanked when blank_lz=1 and disp_reg nibbles i..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives seg[6:0]=7'h7F; dp is still honoured and an is still asserted.
- No combinational path from any input to any output.

Test Plan (CLK_DIV=4):
- Reset release -> an=1111, seg=FF; after the first edge an=1110, scan_sel=0, seg=C0 ("0"); scan_sel steps 0,1,2,3,0 every 4 cycles; frame_done pulses once per 16 cycles.
- Pulse load with value=16'h12AF, then observe the next full frame -> digits 0..3 show seg=8E, 88, A4, F9, each paired with the matching an (1110, 1101, 1011, 0111).
- Pulse load 16'h1234 during digit 1 of a frame -> the rest of that frame still shows the old value; 16'h1234 appears from digit 0 of the next frame onward.
- Pulse load 16'h0005 coincident with the frame-boundary tick -> digit 0 shows 92 on that same edge.
- blank_lz=1, value=16'h0050 -> digit3=FF, digit2=FF, digit1=92, digit0=C0; value=16'h0000 -> digits 3..1 = FF, digit0 = C0.
- dp_en=4'b0100 with digit 2 blanked -> seg=7F on digit 2. Then assert rst mid-frame with a pending load -> immediate an=1111, seg=FF; after release the display shows 0, not the pending value.
